bp_gshare_param: RTL and testbench

//  Parametrised gshare direction predictor for the F stage; successor to the fixed 6-bit/64-entry predictor.

---
 rtl/bp_gshare_param_pkg.sv | 16 +
 rtl/bp_sat_cntrn.sv | 20 ++
 rtl/bp_gshare_param.sv | 116 +++++++++++
 tb/tb_bp_gshare_param.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/bp_gshare_param_pkg.sv
// Shared gshare predictor defaults and hash-alignment helper.
// Used by the predictor top and by F/BR stages that carry alias/history.
package bp_gshare_param_pkg;

  localparam int BP_HIST_W    = 8;
  localparam int BP_IDX_W     = 8;
  localparam int BP_CNTR_W    = 2;
  localparam int BP_EIP_LSB   = 2;
  localparam int BP_CNTR_INIT = 1;

  // History is left-aligned against the index: its MSB meets the index MSB.
  function automatic int hist_shift(input int idx_w, input int hist_w);
    return idx_w - hist_w;
  endfunction

endpackage

// File: rtl/bp_sat_cntrn.sv
// Saturating up/down counter next-value, no wrap at either end.
module bp_sat_cntrn #(
  parameter int CNTR_W = 2
) (
  input  logic [CNTR_W-1:0] cnt_i,
  input  logic              taken_i,
  output logic [CNTR_W-1:0] cnt_o
);

  // Increment toward all-ones on taken, decrement toward zero otherwise.
  always_comb begin
    cnt_o = cnt_i;
    if (taken_i) begin
      if (!(&cnt_i)) cnt_o = cnt_i + CNTR_W'(1);
    end else begin
      if (|cnt_i)    cnt_o = cnt_i - CNTR_W'(1);
    end
  end

endmodule

// File: rtl/bp_gshare_param.sv
// Parametrised gshare direction predictor.
// Lookup is combinational off registered PHT/GBHR; updates are a 2-stage
// pipeline (capture, then read-modify-write) with forwarding into lookup.
// Optional macro BP_SPEC_HIST_EN: speculative GBHR shift on lookup plus
// repair from upd_ghr on mispredict. Undefined: GBHR shifts only at resolution.
module bp_gshare_param
  import bp_gshare_param_pkg::*;
#(
  parameter int HIST_W    = BP_HIST_W,
  parameter int IDX_W     = BP_IDX_W,
  parameter int CNTR_W    = BP_CNTR_W,
  parameter int EIP_LSB   = BP_EIP_LSB,
  parameter int CNTR_INIT = BP_CNTR_INIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       eip,
  input  logic              lookup,
  output logic              prediction,
  output logic [IDX_W-1:0]  BP_alias,
  output logic [HIST_W-1:0] GBHR,
  input  logic              upd_valid,
  input  logic [IDX_W-1:0]  upd_alias,
  input  logic              upd_taken,
  input  logic [HIST_W-1:0] upd_ghr,
  input  logic              upd_mispredict
);

  localparam int                ENTRIES = 1 << IDX_W;
  localparam int                HSHIFT  = hist_shift(IDX_W, HIST_W);
  localparam logic [CNTR_W-1:0] INIT_V  = CNTR_W'(CNTR_INIT);

  if (HIST_W > IDX_W || HIST_W < 2 || CNTR_W < 2 || EIP_LSB + IDX_W > 32) begin : g_param_chk
    $error("bp_gshare_param: illegal HIST_W/IDX_W/CNTR_W/EIP_LSB combination");
  end

  logic [CNTR_W-1:0] pht_q [ENTRIES];
  logic [HIST_W-1:0] ghr_q, ghr_d;
  logic              wr_vld_q;
  logic [IDX_W-1:0]  wr_alias_q;
  logic              wr_taken_q;
  logic [CNTR_W-1:0] wr_cur, wr_nxt, rd_cnt;
  logic [IDX_W-1:0]  alias_w;

  assign alias_w  = eip[EIP_LSB +: IDX_W] ^ (IDX_W'(ghr_q) << HSHIFT);
  assign BP_alias = alias_w;
  assign GBHR     = ghr_q;

  // Write stage reads the array directly: the previous write has already
  // landed at the edge, so back-to-back updates to one alias chain correctly.
  assign wr_cur = pht_q[wr_alias_q];

  bp_sat_cntrn #(.CNTR_W(CNTR_W)) u_sat (
    .cnt_i   (wr_cur),
    .taken_i (wr_taken_q),
    .cnt_o   (wr_nxt)
  );

  // Lookup read with forwarding from the in-flight write.
  always_comb begin
    rd_cnt = pht_q[alias_w];
    if (wr_vld_q && (wr_alias_q == alias_w)) rd_cnt = wr_nxt;
  end

  assign prediction = rd_cnt[CNTR_W-1];

  // Stage 1: capture the resolved branch; reset drops anything pending.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_vld_q   <= 1'b0;
      wr_alias_q <= '0;
      wr_taken_q <= 1'b0;
    end else begin
      wr_vld_q   <= upd_valid;
      wr_alias_q <= upd_alias;
      wr_taken_q <= upd_taken;
    end
  end

  // Stage 2: PHT write of the saturated next value; reset beats the write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) pht_q[i] <= INIT_V;
    end else if (wr_vld_q) begin
      pht_q[wr_alias_q] <= wr_nxt;
    end
  end

`ifdef BP_SPEC_HIST_EN
  logic sig_unused;
  assign sig_unused = ^eip;

  // Speculative shift on lookup; mispredict repair takes priority.
  always_comb begin
    ghr_d = ghr_q;
    if (upd_valid && upd_mispredict) ghr_d = {upd_ghr[HIST_W-2:0], upd_taken};
    else if (lookup)                 ghr_d = {ghr_q[HIST_W-2:0], prediction};
  end
`else
  logic sig_unused;
  assign sig_unused = ^{eip, upd_ghr, upd_mispredict, lookup};

  // History advances only on resolved branches.
  always_comb begin
    ghr_d = ghr_q;
    if (upd_valid) ghr_d = {ghr_q[HIST_W-2:0], upd_taken};
  end
`endif

  // Global history register.
  always_ff @(posedge clk) begin
    if (!reset) ghr_q <= '0;
    else        ghr_q <= ghr_d;
  end

endmodule

// File: tb/tb_bp_gshare_param.sv
// Directed bench for bp_gshare_param (default parameters). Covers both
// history modes depending on whether BP_SPEC_HIST_EN is defined.
module tb_bp_gshare_param;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] eip;
  logic        lookup;
  logic        prediction;
  logic [7:0]  BP_alias;
  logic [7:0]  GBHR;
  logic        upd_valid;
  logic [7:0]  upd_alias;
  logic        upd_taken;
  logic [7:0]  upd_ghr;
  logic        upd_mispredict;

  int nvec = 0;
  int nerr = 0;
  logic [7:0] ghr_exp = 8'h00;

  always #5 clk = ~clk;

  bp_gshare_param dut (
    .clk            (clk),
    .reset          (reset),
    .eip            (eip),
    .lookup         (lookup),
    .prediction     (prediction),
    .BP_alias       (BP_alias),
    .GBHR           (GBHR),
    .upd_valid      (upd_valid),
    .upd_alias      (upd_alias),
    .upd_taken      (upd_taken),
    .upd_ghr        (upd_ghr),
    .upd_mispredict (upd_mispredict)
  );

  typedef struct {
    logic       is_upd;
    logic [7:0] al;
    logic       tk;
    logic       exp_p;
  } vec_t;

  vec_t tbl[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Point eip at a chosen alias given the expected history, then check.
  task automatic look(input logic [7:0] a, input logic exp_p, input string tag);
    eip = {22'h0, a ^ ghr_exp, 2'b00};
    #1;
    chk({tag, ".pred"},  {31'h0, prediction}, {31'h0, exp_p});
    chk({tag, ".alias"}, {24'h0, BP_alias},   {24'h0, a});
    chk({tag, ".gbhr"},  {24'h0, GBHR},       {24'h0, ghr_exp});
  endtask

  task automatic upd(input logic [7:0] a, input logic tk);
    upd_valid = 1'b1; upd_alias = a; upd_taken = tk; upd_mispredict = 1'b0;
    tick();
    upd_valid = 1'b0;
`ifndef BP_SPEC_HIST_EN
    ghr_exp = {ghr_exp[6:0], tk};
`endif
  endtask

  function automatic vec_t U(input logic [7:0] a, input logic tk);
    vec_t v; v.is_upd = 1'b1; v.al = a; v.tk = tk; v.exp_p = 1'b0; return v;
  endfunction

  function automatic vec_t C(input logic [7:0] a, input logic p);
    vec_t v; v.is_upd = 1'b0; v.al = a; v.tk = 1'b0; v.exp_p = p; return v;
  endfunction

  initial begin
    reset = 1'b0; eip = '0; lookup = 1'b0; upd_valid = 1'b0; upd_alias = '0;
    upd_taken = 1'b0; upd_ghr = '0; upd_mispredict = 1'b0;
    tick(); tick();
    reset = 1'b1;

    // Reset state: eip 0, history 0, weakly not-taken everywhere.
    look(8'h00, 1'b0, "rst0");
    look(8'hff, 1'b0, "rstff");

    // Counter saturation, forwarding, floor at zero, alias isolation.
    tbl.push_back(U(8'h05, 1)); tbl.push_back(U(8'h05, 1)); tbl.push_back(U(8'h05, 1));
    tbl.push_back(C(8'h05, 1));
    tbl.push_back(U(8'h05, 1)); tbl.push_back(C(8'h05, 1));
    tbl.push_back(U(8'h05, 0)); tbl.push_back(C(8'h05, 1));
    tbl.push_back(U(8'h05, 0)); tbl.push_back(C(8'h05, 0));
    tbl.push_back(U(8'h20, 1)); tbl.push_back(C(8'h20, 1));
    tbl.push_back(C(8'h20, 1)); tbl.push_back(C(8'h21, 0));
    tbl.push_back(U(8'h30, 0)); tbl.push_back(U(8'h30, 0)); tbl.push_back(C(8'h30, 0));
    tbl.push_back(U(8'h30, 1)); tbl.push_back(C(8'h30, 0));
    tbl.push_back(U(8'h30, 1)); tbl.push_back(C(8'h30, 1));
    tbl.push_back(U(8'h40, 1)); tbl.push_back(C(8'h41, 0)); tbl.push_back(C(8'h40, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].is_upd) begin
        upd(tbl[i].al, tbl[i].tk);
      end else begin
        look(tbl[i].al, tbl[i].exp_p, $sformatf("tbl%0d", i));
        tick();
      end
    end

    // Reset lands on the edge where a write is pending and another is captured.
    upd_valid = 1'b1; upd_alias = 8'h41; upd_taken = 1'b1;
    tick();
    upd_alias = 8'h42; reset = 1'b0;
    tick();
    reset = 1'b1; upd_valid = 1'b0; ghr_exp = 8'h00;
    look(8'h42, 1'b0, "rpw42");
    look(8'h41, 1'b0, "rpw41");
    look(8'h20, 1'b0, "rpw20");
    tick();
    look(8'h42, 1'b0, "rpw42b");

`ifdef BP_SPEC_HIST_EN
    upd(8'h50, 1); upd(8'h51, 1); upd(8'h52, 1);
    lookup = 1'b1;
    look(8'h50, 1'b1, "spec1"); tick(); ghr_exp = 8'h01;
    look(8'h51, 1'b1, "spec2"); tick(); ghr_exp = 8'h03;
    look(8'h52, 1'b1, "spec3"); tick(); ghr_exp = 8'h07;
    lookup = 1'b0;
    #1 chk("spec.ghr3", {24'h0, GBHR}, 32'h07);
    upd_valid = 1'b1; upd_alias = 8'h60; upd_taken = 1'b0;
    upd_mispredict = 1'b1; upd_ghr = 8'h01;
    tick();
    upd_valid = 1'b0; upd_mispredict = 1'b0;
    chk("spec.repair", {24'h0, GBHR}, 32'h02);
    // Lookup and repair together: repair wins, lookup shift is dropped.
    ghr_exp = 8'h02; lookup = 1'b1;
    upd_valid = 1'b1; upd_alias = 8'h61; upd_taken = 1'b1;
    upd_mispredict = 1'b1; upd_ghr = 8'h10;
    look(8'h50, 1'b1, "spec.both");
    tick();
    lookup = 1'b0; upd_valid = 1'b0; upd_mispredict = 1'b0;
    chk("spec.bothghr", {24'h0, GBHR}, 32'h21);
    // Correctly predicted resolution leaves history alone.
    upd_valid = 1'b1; upd_alias = 8'h62; upd_taken = 1'b1; upd_ghr = 8'hff;
    tick();
    upd_valid = 1'b0;
    chk("spec.okupd", {24'h0, GBHR}, 32'h21);
`else
    // History moves only on resolution; upd_ghr/mispredict/lookup ignored.
    lookup = 1'b1;
    upd_valid = 1'b1; upd_alias = 8'h70; upd_taken = 1'b1;
    upd_mispredict = 1'b1; upd_ghr = 8'haa;
    tick();
    upd_valid = 1'b0;
    chk("ns.upd1", {24'h0, GBHR}, 32'h01);
    eip = 32'h0000_0123;
    tick(); tick();
    chk("ns.lookup", {24'h0, GBHR}, 32'h01);
    upd_valid = 1'b1; upd_taken = 1'b0; upd_ghr = 8'h55;
    tick();
    chk("ns.upd2", {24'h0, GBHR}, 32'h02);
    upd_taken = 1'b1;
    tick();
    upd_valid = 1'b0; lookup = 1'b0; upd_mispredict = 1'b0;
    chk("ns.upd3", {24'h0, GBHR}, 32'h05);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
